// File: rtl/fpadd_sched.sv
// fpadd_sched: round-robin scheduler sharing one fixed-latency FP adder between two
// requesters, with credit-managed per-requester response FIFOs. Optional flush: FPADD_SCHED_FLUSH_EN.
module fpadd_sched #(
  parameter int unsigned LAT       = 4,
  parameter int unsigned RSP_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef FPADD_SCHED_FLUSH_EN
  input  logic        flush,
`endif
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [63:0] req0_op1,
  input  logic [63:0] req0_op2,
  input  logic [2:0]  req0_rm,
  input  logic [3:0]  req0_op_type,
  input  logic        req0_p,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [63:0] req1_op1,
  input  logic [63:0] req1_op2,
  input  logic [2:0]  req1_rm,
  input  logic [3:0]  req1_op_type,
  input  logic        req1_p,
  output logic        add_issue,
  output logic [63:0] add_op1,
  output logic [63:0] add_op2,
  output logic [2:0]  add_rm,
  output logic [3:0]  add_op_type,
  output logic        add_p,
  input  logic [63:0] add_result,
  input  logic [4:0]  add_flags,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [63:0] rsp0_result,
  output logic [4:0]  rsp0_flags,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [63:0] rsp1_result,
  output logic [4:0]  rsp1_flags
);
  localparam int unsigned DW = 64;
  localparam int unsigned FW = 5;
  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned MD = 1 << PW;
  localparam int unsigned CW = 4;

  typedef struct packed {
    logic valid;
    logic id;
  } tag_t;

  tag_t [LAT-1:0]   tag_q, tag_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       req_valid, credit_ok, eligible, grant;
  logic [1:0]       push, pop, rsp_valid, rsp_ready;
  logic [CW-1:0]    inflight [2];
  logic [CW-1:0]    occ [2];
  logic [DW+FW-1:0] rsp_head [2];
  tag_t             tail;

  assign req_valid = {req1_valid, req0_valid};
  assign rsp_ready = {rsp1_ready, rsp0_ready};
  assign tail      = tag_q[LAT-1];

  // Outstanding work per requester: ops still in the adder pipe plus results held in its FIFO
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      inflight[n] = '0;
      for (int i = 0; i < int'(LAT); i++) begin
        if (tag_q[i].valid && (tag_q[i].id == 1'(n))) inflight[n] = inflight[n] + CW'(1);
      end
      credit_ok[n] = (inflight[n] + occ[n]) < CW'(RSP_DEPTH);
    end
  end

  always_comb begin
    eligible = req_valid & credit_ok & {2{reset_n}};
`ifdef FPADD_SCHED_FLUSH_EN
    if (flush) eligible = '0;
`endif
    grant = eligible;
    if (eligible == 2'b11) grant = ptr_q ? 2'b10 : 2'b01;
    ptr_d = ptr_q;
    if (grant[0])      ptr_d = 1'b1;
    else if (grant[1]) ptr_d = 1'b0;
  end

  always_comb begin
    tag_d          = tag_q;
    tag_d[0].valid = |grant;
    tag_d[0].id    = grant[1];
    for (int i = 1; i < int'(LAT); i++) tag_d[i] = tag_q[i-1];
`ifdef FPADD_SCHED_FLUSH_EN
    if (flush) tag_d = '0;
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_q <= '0;
      ptr_q <= 1'b0;
    end else begin
      tag_q <= tag_d;
      ptr_q <= ptr_d;
    end
  end

  always_comb begin
    for (int n = 0; n < 2; n++) begin
      push[n] = tail.valid && (tail.id == 1'(n));
`ifdef FPADD_SCHED_FLUSH_EN
      if (flush) push[n] = 1'b0;
`endif
      pop[n] = rsp_valid[n] & rsp_ready[n];
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_buf
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d;
    logic [CW-1:0]    occ_q, occ_d;
    logic [DW+FW-1:0] mem_q [MD];

    always_comb begin
      rd_d  = rd_q;
      wr_d  = wr_q;
      if (push[n]) wr_d = (wr_q == PW'(RSP_DEPTH - 1)) ? '0 : wr_q + PW'(1);
      if (pop[n])  rd_d = (rd_q == PW'(RSP_DEPTH - 1)) ? '0 : rd_q + PW'(1);
      occ_d = occ_q + CW'(push[n]) - CW'(pop[n]);
`ifdef FPADD_SCHED_FLUSH_EN
      if (flush) begin
        rd_d  = '0;
        wr_d  = '0;
        occ_d = '0;
      end
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        rd_q  <= '0;
        wr_q  <= '0;
        occ_q <= '0;
      end else begin
        rd_q  <= rd_d;
        wr_q  <= wr_d;
        occ_q <= occ_d;
      end
    end

    always_ff @(posedge clk) begin
      if (push[n]) mem_q[wr_q] <= {add_flags, add_result};
    end

    assign occ[n]       = occ_q;
    assign rsp_valid[n] = (occ_q != '0);
    assign rsp_head[n]  = rsp_valid[n] ? mem_q[rd_q] : '0;

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
      !(push[n] && !pop[n] && (occ_q == CW'(RSP_DEPTH))));
  end

  // Operand mux; zero when nothing launches
  always_comb begin
    add_op1     = '0;
    add_op2     = '0;
    add_rm      = '0;
    add_op_type = '0;
    add_p       = 1'b0;
    if (grant[0]) begin
      add_op1     = req0_op1;
      add_op2     = req0_op2;
      add_rm      = req0_rm;
      add_op_type = req0_op_type;
      add_p       = req0_p;
    end else if (grant[1]) begin
      add_op1     = req1_op1;
      add_op2     = req1_op2;
      add_rm      = req1_rm;
      add_op_type = req1_op_type;
      add_p       = req1_p;
    end
  end

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign add_issue  = |grant;
  assign rsp0_valid = rsp_valid[0];
  assign rsp1_valid = rsp_valid[1];
  assign {rsp0_flags, rsp0_result} = rsp_head[0];
  assign {rsp1_flags, rsp1_result} = rsp_head[1];
endmodule

// File: tb/tb_fpadd_sched.sv
// Directed bench for fpadd_sched: vector table of isolated ops plus sequences for
// round-robin contention, FIFO backpressure, reset mid-flight and (optionally) flush.
module tb_fpadd_sched;
  localparam int unsigned LAT = 4;

  logic        clk = 1'b0;
  logic        reset_n;
`ifdef FPADD_SCHED_FLUSH_EN
  logic        flush;
`endif
  logic        req0_valid, req0_ready, req0_p, req1_valid, req1_ready, req1_p;
  logic [63:0] req0_op1, req0_op2, req1_op1, req1_op2;
  logic [2:0]  req0_rm, req1_rm;
  logic [3:0]  req0_op_type, req1_op_type;
  logic        add_issue, add_p;
  logic [63:0] add_op1, add_op2, add_result;
  logic [2:0]  add_rm;
  logic [3:0]  add_op_type;
  logic [4:0]  add_flags;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [63:0] rsp0_result, rsp1_result;
  logic [4:0]  rsp0_flags, rsp1_flags;

  always #5 clk = ~clk;

  fpadd_sched #(.LAT(LAT), .RSP_DEPTH(2)) dut (
    .clk(clk), .reset_n(reset_n),
`ifdef FPADD_SCHED_FLUSH_EN
    .flush(flush),
`endif
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req0_rm(req0_rm), .req0_op_type(req0_op_type), .req0_p(req0_p),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
    .req1_rm(req1_rm), .req1_op_type(req1_op_type), .req1_p(req1_p),
    .add_issue(add_issue), .add_op1(add_op1), .add_op2(add_op2), .add_rm(add_rm),
    .add_op_type(add_op_type), .add_p(add_p), .add_result(add_result), .add_flags(add_flags),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags)
  );

  // Stand-in adder: one known FP sum, integer add otherwise; flags from operand low bits
  function automatic logic [63:0] fp_model(input logic [63:0] a, input logic [63:0] b);
    if (a == 64'h3FF0000000000000 && b == 64'h4000000000000000) return 64'h4008000000000000;
    return a + b;
  endfunction

  typedef struct packed { logic [63:0] r; logic [4:0] f; } ares_t;
  ares_t pipe [LAT];
  always @(posedge clk) begin
    pipe[0] <= '{r: fp_model(add_op1, add_op2), f: add_op1[4:0] ^ add_op2[4:0]};
    for (int i = 1; i < int'(LAT); i++) pipe[i] <= pipe[i-1];
  end
  assign add_result = pipe[LAT-1].r;
  assign add_flags  = pipe[LAT-1].f;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int n, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic [2:0] rm, input logic [3:0] ot, input logic p);
    if (n == 0) begin
      req0_valid = v; req0_op1 = a; req0_op2 = b; req0_rm = rm; req0_op_type = ot; req0_p = p;
    end else begin
      req1_valid = v; req1_op1 = a; req1_op2 = b; req1_rm = rm; req1_op_type = ot; req1_p = p;
    end
  endtask

  task automatic drain(input int cycles, output int c0, output int c1);
    c0 = 0; c1 = 0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (rsp0_valid) c0++;
      if (rsp1_valid) c1++;
      tick();
    end
  endtask

  typedef struct {
    int          req;
    logic [63:0] op1, op2;
    logic [2:0]  rm;
    logic [3:0]  ot;
    logic        p;
    logic [63:0] er;
    logic [4:0]  ef;
  } vec_t;
  vec_t vecs [4];

  task automatic single_op(input vec_t v);
    logic quiet;
    drive(v.req, 1'b1, v.op1, v.op2, v.rm, v.ot, v.p);
    @(negedge clk);
    chk("vec_ready", (v.req == 0) ? req0_ready : req1_ready, 1);
    chk("vec_other_ready", (v.req == 0) ? req1_ready : req0_ready, 0);
    chk("vec_issue", add_issue, 1);
    chk("vec_op1", add_op1, v.op1);
    chk("vec_op2", add_op2, v.op2);
    chk("vec_ctl", {add_rm, add_op_type, add_p}, {v.rm, v.ot, v.p});
    tick();
    drive(v.req, 1'b0, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("vec_idle_zero", {add_issue, add_op1, add_op2}, 0);
    quiet = rsp0_valid | rsp1_valid;
    for (int c = 2; c <= 4; c++) begin
      tick();
      @(negedge clk);
      quiet = quiet | rsp0_valid | rsp1_valid;
    end
    chk("vec_no_early_rsp", quiet, 0);
    tick();
    @(negedge clk);
    chk("vec_rsp_valid", (v.req == 0) ? rsp0_valid : rsp1_valid, 1);
    chk("vec_result", (v.req == 0) ? rsp0_result : rsp1_result, v.er);
    chk("vec_flags", (v.req == 0) ? rsp0_flags : rsp1_flags, v.ef);
    tick();
    @(negedge clk);
    chk("vec_rsp_popped", rsp0_valid | rsp1_valid, 0);
    tick();
  endtask

  initial begin
    int g, g0, g1, got0, got1, d0, d1;
    logic seen;

    vecs[0] = '{0, 64'h3FF0000000000000, 64'h4000000000000000, 3'd0, 4'h0, 1'b0, 64'h4008000000000000, 5'h00};
    vecs[1] = '{1, 64'h0000000000000010, 64'h0000000000000003, 3'd3, 4'h5, 1'b1, 64'h0000000000000013, 5'h13};
    vecs[2] = '{0, 64'hFFFFFFFFFFFFFFFF, 64'h0000000000000001, 3'd7, 4'hF, 1'b1, 64'h0000000000000000, 5'h1E};
    vecs[3] = '{1, 64'h123456789ABCDEF0, 64'h0FEDCBA987654321, 3'd1, 4'h2, 1'b0, 64'h2222222222222211, 5'h11};

    reset_n = 1'b0;
`ifdef FPADD_SCHED_FLUSH_EN
    flush = 1'b0;
`endif
    drive(0, 1'b1, 64'hA, 64'hB, 3'd1, 4'd1, 1'b1);
    drive(1, 1'b1, 64'hC, 64'hD, 3'd2, 4'd2, 1'b0);
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    @(negedge clk);
    chk("rst_ready", {req1_ready, req0_ready}, 0);
    chk("rst_issue", add_issue, 0);
    chk("rst_add_data", {add_op1, add_op2} == '0, 1);
    chk("rst_rsp_valid", {rsp1_valid, rsp0_valid}, 0);
    tick();
    reset_n = 1'b1;
    drive(0, 1'b0, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0);
    drive(1, 1'b0, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0);
    tick();

    for (int i = 0; i < 4; i++) single_op(vecs[i]);

    // Contention: pointer rests at 0 after a req1 grant; grants alternate, streams stay ordered
    g0 = 0; g1 = 0; got0 = 0; got1 = 0;
    for (int c = 0; c < 40; c++) begin
      drive(0, g0 < 3, 64'h1000 + 64'(g0), 64'h1, 3'd0, 4'd0, 1'b0);
      drive(1, g1 < 3, 64'h2000 + 64'(g1), 64'h2, 3'd0, 4'd0, 1'b0);
      @(negedge clk);
      if (c < 4) chk("rr_alternate", {req1_ready, req0_ready}, (c % 2 == 0) ? 2'b01 : 2'b10);
      if (req0_ready) g0++;
      if (req1_ready) g1++;
      if (rsp0_valid) begin chk("rr_rsp0_order", rsp0_result, 64'h1001 + 64'(got0)); got0++; end
      if (rsp1_valid) begin chk("rr_rsp1_order", rsp1_result, 64'h2002 + 64'(got1)); got1++; end
      tick();
    end
    chk("rr_rsp0_count", got0, 3);
    chk("rr_rsp1_count", got1, 3);
    drive(0, 1'b0, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0);
    drive(1, 1'b0, 64'h0, 64'h0, 3'd0, 4'd0, 1'b0);

    // Backpressure: two credits, then a pop frees exactly one grant, one cycle later
    rsp0_ready = 1'b0;
    g = 0;
    for (int c = 0; c < 10; c++) begin
      drive(0, 1'b1, 64'h5000 + 64'(g), 64'h1, 3'd0, 4'd0, 1'b0);
      @(negedge clk);
      if (c < 2) chk("bp_early_grant", req0_ready, 1);
      if (req0_ready) g++;
      tick();
    end
    chk("bp_grant_count", g, 2);
    drive(0, 1'b1, 64'h5000 + 64'(g), 64'h1, 3'd0, 4'd0, 1'b0);
    rsp0_ready = 1'b1;
    @(negedge clk);
    chk("bp_head", rsp0_result, 64'h5001);
    chk("bp_no_same_cycle_grant", req0_ready, 0);
    tick();
    rsp0_ready = 1'b0;
    @(negedge clk);
    chk("bp_regrant", req0_ready, 1);
    tick();
    g = 0;
    drive(0, 1'b1, 64'h5003, 64'h1, 3'd0, 4'd0, 1'b0);
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (req0_ready) g++;
      tick();
    end
    chk("bp_no_extra_grant", g, 0);
    got0 = 0;
    req0_valid = 1'b0;
    rsp0_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp0_valid) begin chk("bp_drain_order", rsp0_result, 64'h5002 + 64'(got0)); got0++; end
      tick();
    end
    chk("bp_drain_count", got0, 2);

    // Reset with three ops in flight; pointer left at 1 beforehand
    drive(0, 1'b1, 64'h6000, 64'h1, 3'd0, 4'd0, 1'b0);
    drive(1, 1'b1, 64'h7000, 64'h1, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("rst_pre_grant1", req1_ready, 1);
    tick();
    @(negedge clk);
    chk("rst_pre_grant0", req0_ready, 1);
    tick();
    req1_valid = 1'b0;
    @(negedge clk);
    chk("rst_pre_grant0_lone", req0_ready, 1);
    tick();
    reset_n = 1'b0;
    req1_valid = 1'b1;
    @(negedge clk);
    chk("rst_mid_ready", {req1_ready, req0_ready, add_issue}, 0);
    tick();
    reset_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      seen = seen | rsp0_valid | rsp1_valid;
      tick();
    end
    chk("rst_no_stale_rsp", seen, 0);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    drive(0, 1'b1, 64'h8000, 64'h1, 3'd0, 4'd0, 1'b0);
    drive(1, 1'b1, 64'h9000, 64'h1, 3'd0, 4'd0, 1'b0);
    g0 = 0; g1 = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (c == 0) chk("rst_ptr_to_0", {req1_ready, req0_ready}, 2'b01);
      if (req0_ready) g0++;
      if (req1_ready) g1++;
      tick();
    end
    chk("rst_full_credit0", g0, 2);
    chk("rst_full_credit1", g1, 2);
    drain(12, d0, d1);
    chk("rst_post_rsp_count", d0 + d1, 4);

`ifdef FPADD_SCHED_FLUSH_EN
    // Flush two cycles after an issue drops that op and frees its credit at once
    drive(0, 1'b1, 64'hA000, 64'h1, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("fl_issue", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    tick();
    flush = 1'b1;
    drive(0, 1'b1, 64'hB000, 64'h1, 3'd0, 4'd0, 1'b0);
    @(negedge clk);
    chk("fl_no_grant", {req1_ready, req0_ready, add_issue}, 0);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("fl_regrant", req0_ready, 1);
    tick();
    req0_valid = 1'b0;
    got0 = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (rsp0_valid) begin chk("fl_rsp_result", rsp0_result, 64'hB001); got0++; end
      tick();
    end
    chk("fl_rsp_count", got0, 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/fpadd_sched.md
FPADD_SCHED -- requirements
Module: fpadd_sched

Interface
REQ-001 SHALL have parameter LAT, default 4: fixed latency of the shared FP add pipeline in cycles, from issue to result; legal range 1..8.
REQ-002 SHALL have parameter RSP_DEPTH, default 2: response buffer entries per requester; legal range 1..4.
REQ-003 SHALL use a single clock and an asynchronous, active-low reset, with ports:
  clk  in  1  rising-edge clock
  reset_n  in  1  asynchronous, active-low reset
  reqN_valid  in  1  request N present (N=0,1)
  reqN_ready  out  1  request N accepted this cycle
  reqN_op1, reqN_op2  in  64  operands
  reqN_rm  in  3  rounding mode
  reqN_op_type  in  4  operation select
  reqN_p  in  1  precision (0=double, 1=single)
  add_issue  out  1  operation launched into the adder this cycle
  add_op1, add_op2  out  64  muxed operands
  add_rm  out  3  muxed rounding mode
  add_op_type  out  4  muxed operation select
  add_p  out  1  muxed precision
  add_result  in  64  adder result, LAT cycles after issue
  add_flags  in  5  adder flags, aligned with add_result
  rspN_valid  out  1  response N available
  rspN_ready  in  1  response N consumed
  rspN_result  out  64  result from head of buffer N
  rspN_flags  out  5  flags from head of buffer N

Function
REQ-004 SHALL keep credit[N] = RSP_DEPTH - (in-flight ops of N + occupancy of buffer N); reqN is eligible when reqN_valid=1 and credit[N]>0.
REQ-005 SHALL grant at most one eligible requester per cycle; reqN_ready = grant[N], combinational.
REQ-006 SHALL arbitrate round-robin: when both are eligible, grant the requester named by a 1-bit priority pointer; after any grant, point the pointer at the other requester.
REQ-007 SHALL grant a lone eligible requester regardless of the pointer.
REQ-008 SHALL drive add_issue = OR of grants, with add_op1/op2/rm/op_type/p taken from the granted requester in the same cycle; add_* data SHALL be 0 when add_issue=0.
REQ-009 SHALL track in-flight ops in an LAT-deep shift register of {valid, id}, shifted every cycle.
REQ-010 SHALL write add_result/add_flags into buffer[id] in the cycle the register tail is valid; rspN_valid rises on the following cycle (request-to-response latency LAT+1).
REQ-011 SHALL present buffer N in FIFO order; pop on rspN_valid & rspN_ready; a simultaneous push and pop on a buffer SHALL both take effect.
REQ-012 SHALL never overflow a buffer; the credit rule of REQ-004 guarantees this. Any push into a full buffer is a design error and SHALL be flagged by an assertion.
REQ-013 SHALL release a credit on the pop, so the freed slot is grantable on the next cycle, not the same cycle.
REQ-014 SHALL keep ordering within each requester strictly in issue order; there are no ordering guarantees across requesters.

Reset
REQ-015 SHALL, while reset_n=0: clear all tag valids; empty both buffers; set the pointer to requester 0; drive reqN_ready, add_issue, rspN_valid and all data outputs to 0.
REQ-016 SHALL discard in-flight ops on reset mid-operation; results returning after reset deasserts SHALL be ignored.

Configuration
REQ-017 SHALL, with macro FPADD_SCHED_FLUSH_EN defined, add input flush (1 bit). A flush=1 cycle: clears all tag valids, empties both buffers, restores full credits, grants nothing. The pointer is unchanged.
REQ-018 SHALL, without FPADD_SCHED_FLUSH_EN, have no flush port and no flush logic.

Verification
REQ-019 Single op: req0 op1=3FF0000000000000, op2=4000000000000000, rm=0 at cycle t; adder model returns 4008000000000000, flags=0 -> add_issue=1 at t; rsp0_valid=1 at t+5 with result 4008000000000000.
REQ-020 Contention: both requesters valid continuously, pointer=0 -> grants alternate 0,1,0,1; each rsp stream is in its own issue order.
REQ-021 Backpressure: rsp0_ready=0, req0 valid continuously -> exactly 2 grants, then req0_ready=0. One rsp0 pop -> exactly 1 further grant, on the next cycle.
REQ-022 Reset mid-operation: reset_n low for 1 cycle with 3 ops in flight -> no rsp*_valid ever asserts for those ops; both buffers empty; full credits available.
REQ-023 Flush (FPADD_SCHED_FLUSH_EN): flush at t+2 after an issue at t -> no response for that op; req0 granted again at t+3.
